// File: rtl/nn_pkg.sv
// Shared types for the neuron/activation pipeline blocks.
package nn_pkg;

  localparam int NN_DATA_WIDTH = 16;

  typedef logic signed [NN_DATA_WIDTH-1:0] sample_t;

  // COLLECT: fill buffer takes samples; FULL_WAIT: fill complete, output busy
  typedef enum logic [0:0] {
    COLLECT   = 1'b0,
    FULL_WAIT = 1'b1
  } collector_state_e;

endpackage

// File: rtl/vector_out_stage.sv
// Parallel output register with valid/ready hold. The caller asserts load
// only when the register is free (empty, or draining this cycle).
module vector_out_stage #(
  parameter int VEC_LEN    = 10,
  parameter int DATA_WIDTH = nn_pkg::NN_DATA_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      load,
  input  logic signed [VEC_LEN-1:0][DATA_WIDTH-1:0] load_data,
  input  logic                                      ready_in,
  output logic signed [VEC_LEN-1:0][DATA_WIDTH-1:0] vec_out,
  output logic                                      valid_out
);

  // Load wins over drain so a back-to-back replacement keeps valid_out high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_out   <= '0;
      valid_out <= 1'b0;
    end else if (load) begin
      vec_out   <= load_data;
      valid_out <= 1'b1;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/activation_collector.sv
// Packs the scalar activation stream into VEC_LEN-lane vectors, with one
// fill buffer behind one output register, partial flush and sticky overflow.
module activation_collector
  import nn_pkg::*;
#(
  parameter int  VEC_LEN    = 10,
  parameter int  DATA_WIDTH = NN_DATA_WIDTH,
  localparam int CNT_WIDTH  = $clog2(VEC_LEN + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      valid_in,
  input  logic signed [DATA_WIDTH-1:0]              in_data,
  input  logic                                      flush,
  output logic                                      in_ready,
  output logic signed [VEC_LEN-1:0][DATA_WIDTH-1:0] vec_out,
  output logic                                      valid_out,
  input  logic                                      ready_in,
  output logic [CNT_WIDTH-1:0]                      fill_count,
  output logic                                      overflow
);

  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(VEC_LEN - 1);

  collector_state_e                          state;
  logic signed [VEC_LEN-1:0][DATA_WIDTH-1:0] fill;
  logic signed [VEC_LEN-1:0][DATA_WIDTH-1:0] next_vec;
  logic signed [VEC_LEN-1:0][DATA_WIDTH-1:0] load_data;
  logic [CNT_WIDTH-1:0]                      wr_cnt;
  logic accept, full_done, flush_done, complete, out_free, drain, load;

  assign in_ready   = (state == COLLECT);
  assign accept     = valid_in && in_ready;
  assign wr_cnt     = fill_count + CNT_WIDTH'(accept);
  assign full_done  = accept && (fill_count == LAST_LANE);
  assign flush_done = flush && in_ready && ((fill_count != '0) || accept);
  assign complete   = full_done || flush_done;
  assign drain      = valid_out && ready_in;
  assign out_free   = !valid_out || ready_in;

  // Fill buffer after this cycle's write; lanes past the write count read 0
  // (this is the flush padding, and a no-op otherwise since they are clear)
  always_comb begin
    next_vec = fill;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (accept && (fill_count == CNT_WIDTH'(i)))
        next_vec[i] = in_data;
      else if (CNT_WIDTH'(i) >= wr_cnt)
        next_vec[i] = '0;
    end
  end

  // Output register takes a fresh completion, or the parked buffer on drain
  always_comb begin
    load      = 1'b0;
    load_data = next_vec;
    if (state == FULL_WAIT) begin
      load      = drain;
      load_data = fill;
    end else begin
      load      = complete && out_free;
    end
  end

  // Collector FSM: counter, fill buffer and overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      fill       <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (complete && out_free) begin
            fill       <= '0;
            fill_count <= '0;
          end else if (complete) begin
            fill       <= next_vec;
            fill_count <= wr_cnt;
            state      <= FULL_WAIT;
          end else if (accept) begin
            fill       <= next_vec;
            fill_count <= wr_cnt;
          end
        end
        FULL_WAIT: begin
          // No upstream backpressure: a sample here is lost
          if (valid_in) overflow <= 1'b1;
          if (drain) begin
            fill       <= '0;
            fill_count <= '0;
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  vector_out_stage #(
    .VEC_LEN    (VEC_LEN),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .ready_in  (ready_in),
    .vec_out   (vec_out),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_activation_collector.sv
// Directed bench for activation_collector (VEC_LEN=4) with a vector scoreboard.
module tb_activation_collector;

  localparam int VL = 4;
  localparam int DW = 16;
  localparam int CW = $clog2(VL + 1);

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            valid_in;
  logic signed [DW-1:0]            in_data;
  logic                            flush;
  logic                            in_ready;
  logic signed [VL-1:0][DW-1:0]    vec_out;
  logic                            valid_out;
  logic                            ready_in;
  logic [CW-1:0]                   fill_count;
  logic                            overflow;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  activation_collector #(.VEC_LEN(VL), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .in_data    (in_data),
    .flush      (flush),
    .in_ready   (in_ready),
    .vec_out    (vec_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .fill_count (fill_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    pack4 = {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    valid_in = 1'b1;
    in_data  = 16'(v);
    step();
    valid_in = 1'b0;
  endtask

  // Transfer is decided on the next rising edge; compare against scoreboard
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      if (sb_q.size() == 0) chk("sb_unexpected_valid", {63'd0, valid_out}, 64'd0);
      else chk("sb_vec", vec_out, sb_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; in_data = '0; flush = 1'b0; ready_in = 1'b1;
    step(); step();
    rst_n = 1'b1;
    chk("rst_fill_count", 64'(fill_count), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_vec", vec_out, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // reset mid-fill discards the partial vector
    push(1); push(2);
    chk("midfill_count", 64'(fill_count), 64'd2);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_count", 64'(fill_count), 64'd0);
    chk("midrst_valid", 64'(valid_out), 64'd0);
    chk("midrst_vec", vec_out, 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);

    // basic pack, negative sample passes through unchanged
    push(5); push(-3); push(7);
    sb_q.push_back(pack4(5, -3, 7, 100));
    push(100);
    chk("basic_valid", 64'(valid_out), 64'd1);
    chk("basic_vec", vec_out, pack4(5, -3, 7, 100));
    chk("basic_count", 64'(fill_count), 64'd0);
    step();
    chk("basic_drop", 64'(valid_out), 64'd0);

    // backpressure fills the second buffer, then FULL_WAIT
    ready_in = 1'b0;
    sb_q.push_back(pack4(1, 2, 3, 4));
    sb_q.push_back(pack4(5, 6, 7, 8));
    push(1); push(2); push(3); push(4);
    chk("bp_vec1", vec_out, pack4(1, 2, 3, 4));
    chk("bp_valid1", 64'(valid_out), 64'd1);
    push(5); push(6); push(7); push(8);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_full_count", 64'(fill_count), 64'd4);
    chk("bp_hold_vec", vec_out, pack4(1, 2, 3, 4));
    // sample during FULL_WAIT is dropped
    push(9);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_hold_vec", vec_out, pack4(1, 2, 3, 4));
    chk("ovf_count", 64'(fill_count), 64'd4);
    ready_in = 1'b1;
    step();
    chk("bp_vec2", vec_out, pack4(5, 6, 7, 8));
    chk("bp_valid2", 64'(valid_out), 64'd1);
    chk("bp_in_ready2", 64'(in_ready), 64'd1);
    chk("bp_count2", 64'(fill_count), 64'd0);
    step();
    chk("bp_drain_valid", 64'(valid_out), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // flush of a partial vector pads with zeros
    push(11); push(22);
    flush = 1'b1;
    sb_q.push_back(pack4(11, 22, 0, 0));
    step();
    flush = 1'b0;
    chk("flush_valid", 64'(valid_out), 64'd1);
    chk("flush_vec", vec_out, pack4(11, 22, 0, 0));
    chk("flush_count", 64'(fill_count), 64'd0);
    // sample and flush together
    flush = 1'b1;
    sb_q.push_back(pack4(33, 0, 0, 0));
    push(33);
    flush = 1'b0;
    chk("flush1_vec", vec_out, pack4(33, 0, 0, 0));
    chk("flush1_valid", 64'(valid_out), 64'd1);
    step();
    chk("flush1_drop", 64'(valid_out), 64'd0);
    // flush with empty buffer is a no-op
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_empty_valid", 64'(valid_out), 64'd0);
    chk("flush_empty_count", 64'(fill_count), 64'd0);
    // flush on the final lane is an ordinary full vector
    push(41); push(42); push(43);
    flush = 1'b1;
    sb_q.push_back(pack4(41, 42, 43, 44));
    push(44);
    flush = 1'b0;
    chk("flush_last_vec", vec_out, pack4(41, 42, 43, 44));
    chk("flush_last_count", 64'(fill_count), 64'd0);
    step();
    chk("flush_last_drop", 64'(valid_out), 64'd0);

    // drain and completion in the same cycle: no FULL_WAIT
    ready_in = 1'b0;
    sb_q.push_back(pack4(1, 2, 3, 4));
    sb_q.push_back(pack4(5, 6, 7, 8));
    push(1); push(2); push(3); push(4);
    push(5); push(6); push(7);
    chk("sim_in_ready_pre", 64'(in_ready), 64'd1);
    chk("sim_count_pre", 64'(fill_count), 64'd3);
    ready_in = 1'b1;
    push(8);
    chk("sim_valid", 64'(valid_out), 64'd1);
    chk("sim_vec", vec_out, pack4(5, 6, 7, 8));
    chk("sim_in_ready", 64'(in_ready), 64'd1);
    chk("sim_count", 64'(fill_count), 64'd0);
    step();
    chk("sim_drop", 64'(valid_out), 64'd0);
    chk("ovf_final", 64'(overflow), 64'd1);
    step();
    chk("sb_leftover", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
